// File: rtl/sorting_pkg.sv
// Shared types and helpers for the packet-sorter dedup stage.
//   dedup_state_t : FSM encoding for sorting_dedup
//   calc_cwidth   : width of a counter able to hold 0..max_len
package sorting_pkg;

   typedef enum logic [1:0] {
      IDLE_S   = 2'd0,
      IN_PKT_S = 2'd1,
      FLUSH_S  = 2'd2
   } dedup_state_t;

   function automatic int calc_cwidth(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sorting_dedup.sv
// sorting_dedup: removes adjacent duplicate words from sorted Avalon-ST
// packets, re-frames sop/eop on the surviving words and reports a running
// per-packet count of emitted words.
// Ports:
//   clk_i, rst_n_i                     clock, async active-low reset
//   snk_data_i/_startofpacket_i/_endofpacket_i/_valid_i, snk_ready_o
//                                      input stream (sorted ascending)
//   src_data_o/_startofpacket_o/_endofpacket_o/_valid_o, src_ready_i
//                                      deduplicated output stream
//   src_uniq_cnt_o                     unique-word count incl. current beat
//   err_o                              one-cycle pulse on a framing error
module sorting_dedup
   import sorting_pkg::*;
#(
   parameter  int DWIDTH      = 8,
   parameter  int MAX_PKT_LEN = 32,
   localparam int CWIDTH      = calc_cwidth(MAX_PKT_LEN)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_startofpacket_i,
   input  logic              snk_endofpacket_i,
   input  logic              snk_valid_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_startofpacket_o,
   output logic              src_endofpacket_o,
   output logic              src_valid_o,
   input  logic              src_ready_i,
   output logic [CWIDTH-1:0] src_uniq_cnt_o,
   output logic              err_o
);

   logic [1:0]        rst_sync_q;
   logic              rst_n_s;

   dedup_state_t      state_q, state_d;
   logic [DWIDTH-1:0] hold_data_q, hold_data_d;
   logic              hold_sop_q, hold_sop_d;
   logic [DWIDTH-1:0] out_data_q, out_data_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic              out_valid_q, out_valid_d;
   logic [CWIDTH-1:0] out_cnt_q, out_cnt_d;
   logic              err_q, err_d;

   logic              adv_s, acc_s;
   logic              emit_s, emit_sop_s, emit_eop_s;
   logic [DWIDTH-1:0] emit_data_s;

   // Reset synchronizer: assertion propagates immediately, release is aligned to clk_i.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_q[1];

   assign adv_s       = !out_valid_q || src_ready_i;
   assign snk_ready_o = adv_s && (state_q != FLUSH_S);
   assign acc_s       = snk_valid_i && snk_ready_o;

   // Next-state, hold register and emit decision.
   always_comb begin
      state_d     = state_q;
      hold_data_d = hold_data_q;
      hold_sop_d  = hold_sop_q;
      err_d       = 1'b0;
      emit_s      = 1'b0;
      emit_data_s = hold_data_q;
      emit_sop_s  = hold_sop_q;
      emit_eop_s  = 1'b0;
      case (state_q)
         IDLE_S: begin
            if (acc_s) begin
               if (!snk_startofpacket_i) begin
                  err_d = 1'b1;
               end else if (snk_endofpacket_i) begin
                  emit_s      = 1'b1;
                  emit_data_s = snk_data_i;
                  emit_sop_s  = 1'b1;
                  emit_eop_s  = 1'b1;
               end else begin
                  hold_data_d = snk_data_i;
                  hold_sop_d  = 1'b1;
                  state_d     = IN_PKT_S;
               end
            end else begin
               state_d = IDLE_S;
            end
         end
         IN_PKT_S: begin
            if (acc_s && snk_startofpacket_i) begin
               // Missing eop: close the open packet, then restart on this beat.
               emit_s      = 1'b1;
               emit_eop_s  = 1'b1;
               err_d       = 1'b1;
               hold_data_d = snk_data_i;
               hold_sop_d  = 1'b1;
               state_d     = snk_endofpacket_i ? FLUSH_S : IN_PKT_S;
            end else if (acc_s) begin
               if (snk_data_i == hold_data_q) begin
                  if (snk_endofpacket_i) begin
                     emit_s     = 1'b1;
                     emit_eop_s = 1'b1;
                     state_d    = IDLE_S;
                  end else begin
                     state_d = IN_PKT_S;
                  end
               end else begin
                  // A new distinct word proves the held word unique.
                  emit_s      = 1'b1;
                  hold_data_d = snk_data_i;
                  hold_sop_d  = 1'b0;
                  state_d     = snk_endofpacket_i ? FLUSH_S : IN_PKT_S;
               end
            end else begin
               state_d = IN_PKT_S;
            end
         end
         FLUSH_S: begin
            if (adv_s) begin
               emit_s     = 1'b1;
               emit_eop_s = 1'b1;
               state_d    = IDLE_S;
            end else begin
               state_d = FLUSH_S;
            end
         end
         default: begin
            state_d = IDLE_S;
         end
      endcase
   end

   // Output stage next-state: load on emit, drop valid when advancing idle, else hold.
   always_comb begin
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = out_valid_q;
      if (adv_s) begin
         out_valid_d = emit_s;
         if (emit_s) begin
            out_data_d = emit_data_s;
            out_sop_d  = emit_sop_s;
            out_eop_d  = emit_eop_s;
            out_cnt_d  = emit_sop_s ? CWIDTH'(1) : out_cnt_q + CWIDTH'(1);
         end else begin
            out_cnt_d = out_cnt_q;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State, hold and output registers.
   always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q     <= IDLE_S;
         hold_data_q <= '0;
         hold_sop_q  <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_data_q <= hold_data_d;
         hold_sop_q  <= hold_sop_d;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_valid_q <= out_valid_d;
         out_cnt_q   <= out_cnt_d;
         err_q       <= err_d;
      end
   end

   assign src_data_o          = out_data_q;
   assign src_startofpacket_o = out_sop_q;
   assign src_endofpacket_o   = out_eop_q;
   assign src_valid_o         = out_valid_q;
   assign src_uniq_cnt_o      = out_cnt_q;
   assign err_o               = err_q;

endmodule
